// File: rtl/canny_pkg.sv
// Shared types, widths and conventions for the canny edge pipeline.
// Downstream NMS/hysteresis stages import the same sign and mode constants.
package canny_pkg;

  // Magnitude mode select
  localparam logic MAG_L1  = 1'b0;
  localparam logic MAG_MAX = 1'b1;

  // Gradient sign convention: a set sign bit marks the heavier left column / bottom row
  localparam logic GX_SGN_LEFT   = 1'b1;
  localparam logic GX_SGN_RIGHT  = 1'b0;
  localparam logic GY_SGN_BOTTOM = 1'b1;
  localparam logic GY_SGN_TOP    = 1'b0;

  // a+2b+c of unsigned pixels peaks at 4*(2^pix_w-1)
  function automatic int unsigned grad_w(input int unsigned pix_w);
    return pix_w + 2;
  endfunction

  // |gx|+|gy| needs one extra bit over a single gradient
  function automatic int unsigned mag_w(input int unsigned pix_w);
    return pix_w + 3;
  endfunction

endpackage

// File: rtl/sobel_line_buf.sv
// Two chained row buffers: lb0 holds the previous row, lb1 the row before it.
// Reads are combinational and return the contents from before this cycle's write.
module sobel_line_buf
  import canny_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  localparam int unsigned CW = $clog2(IMG_W)
) (
  input  logic             clk,
  input  logic             en_i,
  input  logic [CW-1:0]    addr_i,
  input  logic [PIX_W-1:0] din_i,
  output logic [PIX_W-1:0] dout0_o,
  output logic [PIX_W-1:0] dout1_o
);

  logic [PIX_W-1:0] lb0_mem [IMG_W];
  logic [PIX_W-1:0] lb1_mem [IMG_W];

  assign dout0_o = lb0_mem[addr_i];
  assign dout1_o = lb1_mem[addr_i];

  // Contents are left unreset; rows not yet written this frame are masked by the caller
  always_ff @(posedge clk) begin
    if (en_i) begin
      lb0_mem[addr_i] <= din_i;
      lb1_mem[addr_i] <= lb0_mem[addr_i];
    end
  end

endmodule

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel engine: raster pixels in, |Gx|/|Gy|/signs/magnitude/edge out.
// Two pipeline stages behind a single advance enable; results only for interior pixels.
module sobel_stream_core
  import canny_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480,
  localparam int unsigned GRAD_W = grad_w(PIX_W),
  localparam int unsigned MAG_W  = mag_w(PIX_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [PIX_W-1:0]  in_pix_i,
  input  logic              in_sof_i,
  input  logic              mag_mode_i,
  input  logic [MAG_W-1:0]  thresh_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [GRAD_W-1:0] out_gx_o,
  output logic              out_gx_sgn_o,
  output logic [GRAD_W-1:0] out_gy_o,
  output logic              out_gy_sgn_o,
  output logic [MAG_W-1:0]  out_mag_o,
  output logic              out_edge_o,
  output logic              out_sof_o,
  output logic              out_eof_o
);

  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] ColLast = CW'(IMG_W - 1);
  localparam logic [RW-1:0] RowLast = RW'(IMG_H - 1);

  function automatic logic [GRAD_W-1:0] wsum(input logic [PIX_W-1:0] a,
                                             input logic [PIX_W-1:0] b,
                                             input logic [PIX_W-1:0] c);
    return GRAD_W'(a) + (GRAD_W'(b) << 1) + GRAD_W'(c);
  endfunction

  // Handshake
  logic advance, accept;
  logic out_valid_q;

  assign advance    = out_ready_i | ~out_valid_q;
  assign accept     = in_valid_i & advance;
  assign in_ready_o = advance;

  // Position of the pixel being offered; sof forces (0,0)
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;

  assign cur_col = in_sof_i ? '0 : col_q;
  assign cur_row = in_sof_i ? '0 : row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (cur_col == ColLast) begin
        col_d = '0;
        row_d = (cur_row == RowLast) ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  // Line buffers supply the two rows above the incoming pixel
  logic [PIX_W-1:0] lb0_pix, lb1_pix;

  sobel_line_buf #(
    .PIX_W(PIX_W),
    .IMG_W(IMG_W)
  ) u_line_buf (
    .clk    (clk),
    .en_i   (accept),
    .addr_i (cur_col),
    .din_i  (in_pix_i),
    .dout0_o(lb0_pix),
    .dout1_o(lb1_pix)
  );

  // Window columns, index 0 = top row, 2 = bottom row; right column is the live input
  logic [2:0][PIX_W-1:0] win_l_q, win_m_q, win_r;

  assign win_r = {in_pix_i, lb0_pix, lb1_pix};

  always_ff @(posedge clk) begin
    if (!reset) begin
      win_l_q <= '0;
      win_m_q <= '0;
    end else if (accept) begin
      win_l_q <= win_m_q;
      win_m_q <= win_r;
    end
  end

  // Stage 1: weighted sums on the window including the pixel being accepted
  logic [GRAD_W-1:0] sum_l, sum_r, sum_t, sum_b;
  logic              in_region;

  assign sum_l = wsum(win_l_q[0], win_l_q[1], win_l_q[2]);
  assign sum_r = wsum(win_r[0], win_r[1], win_r[2]);
  assign sum_t = wsum(win_l_q[0], win_m_q[0], win_r[0]);
  assign sum_b = wsum(win_l_q[2], win_m_q[2], win_r[2]);
  assign in_region = (cur_row >= RW'(2)) && (cur_col >= CW'(2));

  logic              s1_valid_q, s1_valid_d;
  logic [GRAD_W-1:0] s1_gx_q, s1_gx_d, s1_gy_q, s1_gy_d;
  logic              s1_gx_sgn_q, s1_gx_sgn_d, s1_gy_sgn_q, s1_gy_sgn_d;
  logic              s1_mode_q, s1_mode_d, s1_sof_q, s1_sof_d, s1_eof_q, s1_eof_d;
  logic [MAG_W-1:0]  s1_thresh_q, s1_thresh_d;

  always_comb begin
    s1_valid_d  = accept & in_region;
    s1_gx_sgn_d = (sum_l > sum_r) ? GX_SGN_LEFT : GX_SGN_RIGHT;
    s1_gx_d     = (sum_l > sum_r) ? sum_l - sum_r : sum_r - sum_l;
    s1_gy_sgn_d = (sum_b > sum_t) ? GY_SGN_BOTTOM : GY_SGN_TOP;
    s1_gy_d     = (sum_b > sum_t) ? sum_b - sum_t : sum_t - sum_b;
    s1_mode_d   = mag_mode_i;
    s1_thresh_d = thresh_i;
    s1_sof_d    = (cur_row == RW'(2)) && (cur_col == CW'(2));
    s1_eof_d    = (cur_row == RowLast) && (cur_col == ColLast);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_q  <= 1'b0;
      s1_gx_q     <= '0;
      s1_gx_sgn_q <= 1'b0;
      s1_gy_q     <= '0;
      s1_gy_sgn_q <= 1'b0;
      s1_mode_q   <= 1'b0;
      s1_thresh_q <= '0;
      s1_sof_q    <= 1'b0;
      s1_eof_q    <= 1'b0;
    end else if (advance) begin
      s1_valid_q  <= s1_valid_d;
      s1_gx_q     <= s1_gx_d;
      s1_gx_sgn_q <= s1_gx_sgn_d;
      s1_gy_q     <= s1_gy_d;
      s1_gy_sgn_q <= s1_gy_sgn_d;
      s1_mode_q   <= s1_mode_d;
      s1_thresh_q <= s1_thresh_d;
      s1_sof_q    <= s1_sof_d;
      s1_eof_q    <= s1_eof_d;
    end
  end

  // Stage 2: magnitude and threshold
  logic [MAG_W-1:0] mag_l1, mag_max, mag_d;
  logic             edge_d;

  always_comb begin
    mag_l1  = MAG_W'(s1_gx_q) + MAG_W'(s1_gy_q);
    mag_max = (s1_gx_q > s1_gy_q) ? MAG_W'(s1_gx_q) : MAG_W'(s1_gy_q);
    mag_d   = (s1_mode_q == MAG_MAX) ? mag_max : mag_l1;
    edge_d  = (mag_d >= s1_thresh_q);
  end

  logic [GRAD_W-1:0] out_gx_q, out_gy_q;
  logic              out_gx_sgn_q, out_gy_sgn_q, out_edge_q, out_sof_q, out_eof_q;
  logic [MAG_W-1:0]  out_mag_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid_q  <= 1'b0;
      out_gx_q     <= '0;
      out_gx_sgn_q <= 1'b0;
      out_gy_q     <= '0;
      out_gy_sgn_q <= 1'b0;
      out_mag_q    <= '0;
      out_edge_q   <= 1'b0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
    end else if (advance) begin
      out_valid_q  <= s1_valid_q;
      out_gx_q     <= s1_gx_q;
      out_gx_sgn_q <= s1_gx_sgn_q;
      out_gy_q     <= s1_gy_q;
      out_gy_sgn_q <= s1_gy_sgn_q;
      out_mag_q    <= mag_d;
      out_edge_q   <= edge_d;
      out_sof_q    <= s1_sof_q;
      out_eof_q    <= s1_eof_q;
    end
  end

  assign out_valid_o  = out_valid_q;
  assign out_gx_o     = out_gx_q;
  assign out_gx_sgn_o = out_gx_sgn_q;
  assign out_gy_o     = out_gy_q;
  assign out_gy_sgn_o = out_gy_sgn_q;
  assign out_mag_o    = out_mag_q;
  assign out_edge_o   = out_edge_q;
  assign out_sof_o    = out_sof_q;
  assign out_eof_o    = out_eof_q;

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed bench for sobel_stream_core on a 5x5 image: hand tables plus a direct 3x3 reference.
module tb_sobel_stream_core;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, in_sof, mag_mode;
  logic [7:0]  in_pix;
  logic [10:0] thresh;
  logic        out_valid, out_ready;
  logic [9:0]  out_gx, out_gy;
  logic        out_gx_sgn, out_gy_sgn, out_edge, out_sof, out_eof;
  logic [10:0] out_mag;

  sobel_stream_core #(
    .PIX_W(8),
    .IMG_W(5),
    .IMG_H(5)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_pix_i    (in_pix),
    .in_sof_i    (in_sof),
    .mag_mode_i  (mag_mode),
    .thresh_i    (thresh),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_gx_o    (out_gx),
    .out_gx_sgn_o(out_gx_sgn),
    .out_gy_o    (out_gy),
    .out_gy_sgn_o(out_gy_sgn),
    .out_mag_o   (out_mag),
    .out_edge_o  (out_edge),
    .out_sof_o   (out_sof),
    .out_eof_o   (out_eof)
  );

  typedef struct packed {
    logic [9:0]  gx;
    logic        gxs;
    logic [9:0]  gy;
    logic        gys;
    logic [10:0] mag;
    logic        edg;
    logic        sof;
    logic        eof;
  } res_t;

  int   n_chk = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   mark_cyc = -1;
  int   first_res_cyc = -1;
  logic [7:0] img [5][5];
  res_t got_q[$];
  res_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t mk(int gx, bit gxs, int gy, bit gys, int mag, bit edg, bit sof,
                              bit eof);
    res_t r;
    r.gx = 10'(gx); r.gxs = gxs; r.gy = 10'(gy); r.gys = gys;
    r.mag = 11'(mag); r.edg = edg; r.sof = sof; r.eof = eof;
    return r;
  endfunction

  function automatic res_t cur_out();
    return mk(int'(out_gx), out_gx_sgn, int'(out_gy), out_gy_sgn, int'(out_mag), out_edge,
              out_sof, out_eof);
  endfunction

  // Direct 3x3 Sobel on the image centred at (r,c)
  function automatic res_t ref_px(int r, int c, bit mode, int th);
    int l, rt, t, b, gx, gy, mag;
    l   = img[r-1][c-1] + 2 * img[r][c-1] + img[r+1][c-1];
    rt  = img[r-1][c+1] + 2 * img[r][c+1] + img[r+1][c+1];
    t   = img[r-1][c-1] + 2 * img[r-1][c] + img[r-1][c+1];
    b   = img[r+1][c-1] + 2 * img[r+1][c] + img[r+1][c+1];
    gx  = (l > rt) ? l - rt : rt - l;
    gy  = (b > t) ? b - t : t - b;
    mag = mode ? ((gx > gy) ? gx : gy) : gx + gy;
    return mk(gx, l > rt, gy, b > t, mag, mag >= th, r == 1 && c == 1, r == 3 && c == 3);
  endfunction

  task automatic ref_frame(input bit mode, input int th);
    for (int r = 1; r <= 3; r++)
      for (int c = 1; c <= 3; c++) exp_q.push_back(ref_px(r, c, mode, th));
  endtask

  always begin
    @(negedge clk);
    #2;
    if (out_valid && out_ready) begin
      if (out_sof && first_res_cyc < 0) first_res_cyc = cyc;
      got_q.push_back(cur_out());
    end
  end

  task automatic send_pix(input logic [7:0] pix, input bit sof, input bit mark);
    int  guard;
    bit  acc;
    guard    = 0;
    acc      = 1'b0;
    in_valid = 1'b1;
    in_pix   = pix;
    in_sof   = sof;
    while (!acc) begin
      @(negedge clk);
      #4;
      acc = in_ready;
      if (acc && mark) mark_cyc = cyc;
      @(posedge clk);
      #1;
      guard++;
      if (!acc && guard > 200) begin
        check_eq("accept_timeout", 1, 0);
        break;
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input bit use_sof, input bit gaps);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        if (gaps) for (int g = 0; g < 4 && $urandom_range(0, 1) == 1; g++) idle(1);
        send_pix(img[r][c], use_sof && r == 0 && c == 0, r == 2 && c == 2);
      end
  endtask

  task automatic compare_q(input string name);
    int n;
    check_eq($sformatf("%s_count", name), got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s[%0d].gx", name, i), got_q[i].gx, exp_q[i].gx);
      check_eq($sformatf("%s[%0d].gx_sgn", name, i), got_q[i].gxs, exp_q[i].gxs);
      check_eq($sformatf("%s[%0d].gy", name, i), got_q[i].gy, exp_q[i].gy);
      check_eq($sformatf("%s[%0d].gy_sgn", name, i), got_q[i].gys, exp_q[i].gys);
      check_eq($sformatf("%s[%0d].mag", name, i), got_q[i].mag, exp_q[i].mag);
      check_eq($sformatf("%s[%0d].edge", name, i), got_q[i].edg, exp_q[i].edg);
      check_eq($sformatf("%s[%0d].sof", name, i), got_q[i].sof, exp_q[i].sof);
      check_eq($sformatf("%s[%0d].eof", name, i), got_q[i].eof, exp_q[i].eof);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic rand_img();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) img[r][c] = 8'($urandom_range(0, 255));
  endtask

  int   vs_gx[3]  = '{400, 400, 0};
  bit   vs_edg[3] = '{1, 1, 0};
  int   hs_gy[3]  = '{1020, 1020, 0};
  bit   hs_gys[3] = '{1, 1, 0};
  res_t snap;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_pix    = '0;
    in_sof    = 1'b0;
    mag_mode  = 1'b0;
    thresh    = 11'd255;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_gx", out_gx, 0);
    check_eq("rst_out_mag", out_mag, 0);
    check_eq("rst_out_flags", {out_gx_sgn, out_gy_sgn, out_edge, out_sof, out_eof}, 0);
    reset     = 1'b1;
    out_ready = 1'b1;
    idle(1);

    // Flat image
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = 8'd50;
    for (int k = 0; k < 9; k++) exp_q.push_back(mk(0, 0, 0, 0, 0, 0, k == 0, k == 8));
    first_res_cyc = -1;
    send_frame(1'b1, 1'b0);
    idle(6);
    check_eq("latency", first_res_cyc - mark_cyc, 2);
    compare_q("flat");

    // Vertical step, L1
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = (c >= 2) ? 8'd100 : 8'd0;
    for (int k = 0; k < 9; k++)
      exp_q.push_back(mk(vs_gx[k%3], 0, 0, 0, vs_gx[k%3], vs_edg[k%3], k == 0, k == 8));
    send_frame(1'b1, 1'b0);
    idle(6);
    compare_q("vstep");

    // Horizontal step, max mode
    mag_mode = 1'b1;
    for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) img[r][c] = (r >= 2) ? 8'd255 : 8'd0;
    for (int k = 0; k < 9; k++)
      exp_q.push_back(mk(0, 0, hs_gy[k/3], hs_gys[k/3], hs_gy[k/3], hs_gys[k/3], k == 0, k == 8));
    send_frame(1'b1, 1'b0);
    idle(6);
    compare_q("hstep");

    // Backpressure mid-stream
    mag_mode = 1'b0;
    rand_img();
    ref_frame(1'b0, 255);
    fork
      send_frame(1'b1, 1'b0);
      begin
        int g;
        g = 0;
        do begin
          @(negedge clk);
          g++;
        end while (!(out_valid && got_q.size() >= 2) && g < 500);
        check_eq("bp_found_valid", out_valid, 1);
        out_ready = 1'b0;
        #2;
        snap = cur_out();
        check_eq("bp_in_ready", in_ready, 0);
        repeat (2) begin
          @(negedge clk);
          #2;
          check_eq("bp_in_ready_hold", in_ready, 0);
          check_eq("bp_out_valid_hold", out_valid, 1);
          check_eq("bp_out_hold", cur_out(), snap);
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    idle(6);
    compare_q("bp");

    // Two back-to-back frames with random input gaps
    rand_img();
    mag_mode = 1'b0;
    thresh   = 11'd300;
    ref_frame(1'b0, 300);
    send_frame(1'b1, 1'b1);
    rand_img();
    mag_mode = 1'b1;
    thresh   = 11'd200;
    ref_frame(1'b1, 200);
    send_frame(1'b1, 1'b1);
    idle(6);
    compare_q("gaps");

    // Reset mid-frame, then a frame without sof must still start at (0,0)
    mag_mode = 1'b0;
    thresh   = 11'd255;
    rand_img();
    for (int i = 0; i < 14; i++) send_pix(img[i/5][i%5], i == 0, 1'b0);
    reset = 1'b0;
    idle(2);
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_in_ready", in_ready, 1);
    reset = 1'b1;
    got_q.delete();
    rand_img();
    ref_frame(1'b0, 255);
    send_frame(1'b0, 1'b0);
    idle(6);
    compare_q("post_rst");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
